// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: scan clock and row inputs in, column drive and key status out.
interface keypad_scanner_if;
  logic       scan_clk;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    output scan_clk,
    output row_in,
    input  col_out,
    input  key_valid,
    input  key_code,
    input  key_held
  );

  modport slave (
    input  scan_clk,
    input  row_in,
    output col_out,
    output key_valid,
    output key_code,
    output key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks active-low columns on each scan tick and debounces
// both the press and the release before reporting a key.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  keypad_scanner_if.slave  kp
);

  localparam logic [7:0] LP_TICKS = 8'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic       r_sc_s1;
  logic       r_sc_s2;
  logic       r_sc_d;
  logic [3:0] r_row_s1;
  logic [3:0] r_row_s2;

  logic       w_tick;
  logic       w_pressed;
  logic [1:0] w_row_idx;

  logic [1:0] r_col;
  logic [1:0] w_col_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic       w_cnt_done;
  logic [1:0] r_row;
  logic [1:0] w_row_nxt;
  logic       w_accept;
  logic       r_key_valid;
  logic [3:0] r_key_code;

  // scan_clk is sampled as data; its synchronized rising edge is the tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sc_s1  <= 1'b0;
      r_sc_s2  <= 1'b0;
      r_sc_d   <= 1'b0;
      r_row_s1 <= '0;
      r_row_s2 <= '0;
    end else begin
      r_sc_s1  <= kp.scan_clk;
      r_sc_s2  <= r_sc_s1;
      r_sc_d   <= r_sc_s2;
      r_row_s1 <= kp.row_in;
      r_row_s2 <= r_row_s1;
    end
  end

  assign w_tick    = r_sc_s2 & ~r_sc_d;
  assign w_pressed = ~&r_row_s2;

  always_comb begin
    w_row_idx = 2'd3;
    if (!r_row_s2[0])      w_row_idx = 2'd0;
    else if (!r_row_s2[1]) w_row_idx = 2'd1;
    else if (!r_row_s2[2]) w_row_idx = 2'd2;
  end

  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_cnt_done = (w_cnt_inc >= LP_TICKS);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= SCAN;
    else          r_state <= w_state_nxt;
  end

  // next-state and datapath next values
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_accept    = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (w_pressed) begin
            w_row_nxt   = w_row_idx;
            w_cnt_nxt   = 8'd1;
            w_state_nxt = DEBOUNCE;
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (w_pressed && (w_row_idx == r_row)) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_done) begin
              w_state_nxt = HELD;
              w_accept    = 1'b1;
            end
          end else begin
            w_state_nxt = SCAN;
          end
        end
        HELD: begin
          if (!w_pressed) begin
            w_cnt_nxt   = 8'd1;
            w_state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (!w_pressed) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_done) begin
              w_col_nxt   = r_col + 2'd1;
              w_state_nxt = SCAN;
            end
          end else begin
            w_state_nxt = HELD;
          end
        end
        default: w_state_nxt = SCAN;
      endcase
    end
  end

  // key_valid is registered so it pulses on the clk after the accepting tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col       <= '0;
      r_cnt       <= '0;
      r_row       <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_col       <= w_col_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row       <= w_row_nxt;
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= {r_row, r_col};
    end
  end

  // outputs
  always_comb begin
    kp.col_out   = ~(4'b0001 << r_col);
    kp.key_held  = (r_state == HELD) || (r_state == RELEASE);
    kp.key_valid = r_key_valid;
    kp.key_code  = r_key_code;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a passive 4x4 switch-matrix model.
module tb_keypad_scanner;

  logic        clk;
  logic        reset_n;
  logic [15:0] keys;
  logic [3:0]  w_rows;
  int          checks;
  int          errors;
  int          vcount;
  int          vpos;

  keypad_scanner_if kif ();

  keypad_scanner #(.DEBOUNCE_TICKS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kp      (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      w_rows[r] = 1'b1;
      for (int unsigned c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.col_out[c]) w_rows[r] = 1'b0;
    end
  end
  assign kif.row_in = w_rows;

  always @(negedge clk)
    if (kif.key_valid === 1'b1) vcount++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one scan_clk period of 8 clk cycles; vpos = negedge index where key_valid was seen
  task automatic tick();
    vpos = -1;
    kif.scan_clk = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (kif.key_valid === 1'b1 && vpos < 0) vpos = int'(i);
    end
    kif.scan_clk = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (kif.key_valid === 1'b1 && vpos < 0) vpos = 4 + int'(i);
    end
  endtask

  initial begin
    logic [3:0] idle_seq [8];
    checks = 0; errors = 0; vcount = 0; vpos = -1;
    reset_n = 1'b0; kif.scan_clk = 1'b0; keys = '0;
    idle_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    repeat (3) @(negedge clk);
    chk("rst_col", 32'(kif.col_out), 32'hE);
    chk("rst_valid", 32'(kif.key_valid), 32'h0);
    chk("rst_code", 32'(kif.key_code), 32'h0);
    chk("rst_held", 32'(kif.key_held), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // idle scan
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      chk("idle_col", 32'(kif.col_out), 32'(idle_seq[i]));
    end
    chk("idle_novalid", 32'(vcount), 32'd0);

    // clean press: row 2 / col 1
    keys = 16'h0200;
    tick();
    chk("press_col_adv", 32'(kif.col_out), 32'hD);
    tick(); tick(); tick();
    chk("press_deb_held", 32'(kif.key_held), 32'h0);
    chk("press_deb_novalid", 32'(vcount), 32'd0);
    tick();
    chk("press_vpos", 32'(vpos), 32'd2);
    chk("press_vcount", 32'(vcount), 32'd1);
    chk("press_code", 32'(kif.key_code), 32'h9);
    chk("press_held", 32'(kif.key_held), 32'h1);
    chk("press_col", 32'(kif.col_out), 32'hD);

    // release with bounce
    keys = '0;
    tick(); tick();
    keys = 16'h0200;
    tick();
    chk("relb_held", 32'(kif.key_held), 32'h1);
    keys = '0;
    tick(); tick(); tick();
    chk("rel3_held", 32'(kif.key_held), 32'h1);
    chk("rel3_col", 32'(kif.col_out), 32'hD);
    tick();
    chk("rel4_held", 32'(kif.key_held), 32'h0);
    chk("rel_col", 32'(kif.col_out), 32'hB);
    chk("rel_vcount", 32'(vcount), 32'd1);
    chk("rel_code", 32'(kif.key_code), 32'h9);

    // press bounce: row 0 / col 3 for two ticks
    keys = 16'h0008;
    tick();
    chk("bnc_col3", 32'(kif.col_out), 32'h7);
    tick(); tick();
    keys = '0;
    tick();
    chk("bnc_back_col", 32'(kif.col_out), 32'h7);
    chk("bnc_held", 32'(kif.key_held), 32'h0);
    tick();
    chk("bnc_adv_col", 32'(kif.col_out), 32'hE);
    chk("bnc_vcount", 32'(vcount), 32'd1);
    chk("bnc_code", 32'(kif.key_code), 32'h9);

    // multi-key: rows 1 and 3 at col 0, lowest row wins
    keys = 16'h1010;
    tick(); tick(); tick(); tick();
    chk("multi_vpos", 32'(vpos), 32'd2);
    chk("multi_code", 32'(kif.key_code), 32'h4);
    chk("multi_vcount", 32'(vcount), 32'd2);
    keys = '0;
    tick(); tick(); tick(); tick();
    chk("multi_rel_col", 32'(kif.col_out), 32'hD);

    // reset in the middle of debounce
    keys = 16'h0200;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("mrst_col", 32'(kif.col_out), 32'hE);
    chk("mrst_code", 32'(kif.key_code), 32'h0);
    chk("mrst_held", 32'(kif.key_held), 32'h0);
    chk("mrst_valid", 32'(kif.key_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tick();
    chk("mrst_restart_col", 32'(kif.col_out), 32'hD);
    chk("mrst_vcount", 32'(vcount), 32'd2);

    // scan clock stopped: state frozen
    tick();
    repeat (50) @(negedge clk);
    chk("stall_held", 32'(kif.key_held), 32'h0);
    chk("stall_col", 32'(kif.col_out), 32'hD);
    chk("stall_vcount", 32'(vcount), 32'd2);
    keys = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
